// File: rtl/ysyx_24100006_pkg.sv
// Shared constants for the ysyx_24100006 core: datapath width and the boot fetch address.
package ysyx_24100006_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h3000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  // Redirect targets may carry junk in bits [1:0]; fetches are always word-aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch unit: one outstanding I$ request, holds the fetched pair until
// the IDU takes it, and squashes any response that a redirect has made stale.
//
//   state  | meaning
//   S_BOOT | one idle cycle after reset, all outputs low
//   S_REQ  | AR request for pc_q presented to the I$
//   S_WAIT | request accepted, waiting for the response beat
//   S_OUT  | instruction/PC pair presented to the IDU
module ysyx_24100006_ifu
  import ysyx_24100006_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            icache_arvalid_o,
  input  logic            icache_arready_i,
  output logic [XLEN-1:0] icache_araddr_o,
  input  logic            icache_rvalid_i,
  output logic            icache_rready_o,
  input  logic [XLEN-1:0] icache_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            discard_q, discard_d;

  logic [XLEN-1:0] redirect_tgt;
  logic            arvalid, rready, ivalid;

  assign redirect_tgt = align_pc(redirect_pc_i);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    pc_out_d  = pc_out_q;
    discard_d = discard_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ivalid    = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        if (redirect_valid_i) pc_d = redirect_tgt;
        state_d = S_REQ;
      end

      S_REQ: begin
        arvalid = 1'b1;
        if (redirect_valid_i) pc_d = redirect_tgt;
        if (icache_arready_i) begin
          // The address just accepted is the pre-redirect PC, so its beat is stale.
          discard_d = redirect_valid_i;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        rready = 1'b1;
        if (redirect_valid_i) pc_d = redirect_tgt;
        if (icache_rvalid_i) begin
          if (redirect_valid_i || discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            inst_d   = icache_rdata_i;
            pc_out_d = pc_q;
            state_d  = S_OUT;
          end
        end else if (redirect_valid_i) begin
          discard_d = 1'b1;
        end
      end

      S_OUT: begin
        ivalid = 1'b1;
        // A redirect drops the held instruction even if the IDU takes it this cycle.
        if (redirect_valid_i) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  assign icache_arvalid_o = rst & arvalid;
  assign icache_rready_o  = rst & rready;
  assign inst_valid_o     = rst & ivalid;
  assign icache_araddr_o  = (rst && arvalid) ? pc_q     : '0;
  assign inst_o           = (rst && ivalid)  ? inst_q   : '0;
  assign pc_o             = (rst && ivalid)  ? pc_out_q : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      pc_out_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pc_out_q  <= pc_out_d;
      discard_q <= discard_d;
    end
  end

endmodule
